// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_pipe
//  Description : WIDTH-bit operation-selectable bitwise logic unit whose
//                results are buffered in a DEPTH-entry output FIFO with
//                valid/ready handshakes on both sides. Reset op is NOT.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       op_load,
    input  logic [2:0]                 op_in,
    output logic [2:0]                 op_cur,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           words_out
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] c_OP_NOT  = 3'b000;
    localparam logic [2:0] c_OP_BUF  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_NAND = 3'b101;
    localparam logic [2:0] c_OP_NOR  = 3'b110;
    localparam logic [2:0] c_OP_XNOR = 3'b111;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_words;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_result;

    // A full FIFO refuses input even when a pop happens in the same cycle,
    // so in_ready depends only on the registered level.
    assign w_full    = (r_level == c_LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign in_ready  = ena & ~w_full;
    assign out_valid = ena & ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign op_cur    = r_op;
    assign level     = r_level;
    assign words_out = r_words;
    assign y         = w_empty ? '0 : r_mem[r_rd_ptr];

    // Bitwise result from the current (pre-load) operation register
    always_comb begin
        w_result = '0;
        case (r_op)
            c_OP_NOT:  w_result = ~a;
            c_OP_BUF:  w_result = a;
            c_OP_AND:  w_result = a & b;
            c_OP_OR:   w_result = a | b;
            c_OP_XOR:  w_result = a ^ b;
            c_OP_NAND: w_result = ~(a & b);
            c_OP_NOR:  w_result = ~(a | b);
            c_OP_XNOR: w_result = ~(a ^ b);
            default:   w_result = '0;
        endcase
    end

    // FIFO storage write; contents need no reset because y is masked when empty
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    // Control state: op register, pointers, occupancy and delivered count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= c_OP_NOT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_words  <= '0;
        end else if (ena) begin
            if (op_load) begin
                r_op <= op_in;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_words  <= r_words + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_gate_pipe
//  Description : Directed self-checking bench for logic_gate_pipe. A second
//                instance with a 4-bit counter shares all inputs to exercise
//                delivered-word counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        op_load;
    logic [2:0]  op_in;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_ready;

    logic [2:0]  op_cur,    op_cur4;
    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [7:0]  y,         y4;
    logic [2:0]  level,     level4;
    logic [15:0] words_out;
    logic [3:0]  words_out4;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_ops [8];

    logic_gate_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .op_load(op_load), .op_in(op_in),
        .op_cur(op_cur), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .level(level),
        .words_out(words_out)
    );

    logic_gate_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .op_load(op_load), .op_in(op_in),
        .op_cur(op_cur4), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
        .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .level(level4),
        .words_out(words_out4)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        exp_ops[0] = 8'h33; exp_ops[1] = 8'hCC; exp_ops[2] = 8'h88; exp_ops[3] = 8'hEE;
        exp_ops[4] = 8'h66; exp_ops[5] = 8'h77; exp_ops[6] = 8'h11; exp_ops[7] = 8'h99;

        rst = 1'b1; ena = 1'b1; op_load = 1'b0; op_in = 3'b000;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;

        // ---- reset defaults ----
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_op_cur",    32'(op_cur),    32'h0);
        chk("rst_level",     32'(level),     32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_y",         32'(y),         32'h0);
        chk("rst_words",     32'(words_out), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);

        // ---- first push with NOT, then pop ----
        a = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("not_out_valid", 32'(out_valid), 32'h1);
        chk("not_y",         32'(y),         32'h5A);
        chk("not_level",     32'(level),     32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_words", 32'(words_out), 32'd1);
        chk("pop_level", 32'(level),     32'h0);
        chk("pop_y",     32'(y),         32'h0);
        chk("pop_valid", 32'(out_valid), 32'h0);

        // ---- every op code on a=CC b=AA ----
        a = 8'hCC; b = 8'hAA; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op_load = 1'b1; op_in = 3'(i);
            step();
            op_load = 1'b0;
            chk($sformatf("op_cur_%0d", i), 32'(op_cur), 32'(i));
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("op_y_%0d", i), 32'(y), 32'(exp_ops[i]));
            step();
        end
        chk("ops_words", 32'(words_out), 32'd9);

        // op load and push in the same cycle: push uses old op (XNOR)
        op_load = 1'b1; op_in = 3'b001; in_valid = 1'b1;
        step();
        op_load = 1'b0;
        chk("same_cyc_y",      32'(y),      32'h99);
        chk("same_cyc_op_cur", 32'(op_cur), 32'h1);
        step();
        in_valid = 1'b0;
        chk("new_op_y", 32'(y), 32'hCC);
        step();
        chk("ops2_words", 32'(words_out), 32'd11);
        chk("ops2_level", 32'(level),     32'h0);

        // ---- fill and backpressure (op = pass A) ----
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 8'(k + 1);
            step();
        end
        chk("full_level",    32'(level),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        a = 8'd5;
        step();
        chk("held_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(in_ready), 32'h0);
        step();
        out_ready = 1'b0;
        chk("full_pop_level", 32'(level),     32'd3);
        chk("full_pop_y",     32'(y),         32'd2);
        chk("full_pop_words", 32'(words_out), 32'd12);
        chk("refill_ready",   32'(in_ready),  32'h1);
        step();
        in_valid = 1'b0;
        chk("refill_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_y_%0d", k), 32'(y), 32'(k + 2));
            step();
        end
        out_ready = 1'b0;
        chk("drain_level",  32'(level),      32'd0);
        chk("drain_words",  32'(words_out),  32'd16);
        chk("drain_words4", 32'(words_out4), 32'd0);

        // ---- streaming 20 words ----
        in_valid = 1'b1; out_ready = 1'b1; a = 8'd0;
        step();
        for (int i = 1; i < 20; i++) begin
            chk($sformatf("stream_y_%0d", i - 1), 32'(y), 32'(i - 1));
            chk($sformatf("stream_lvl_%0d", i - 1), 32'(level), 32'd1);
            a = 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("stream_y_19", 32'(y), 32'd19);
        step();
        out_ready = 1'b0;
        chk("stream_level",  32'(level),      32'd0);
        chk("stream_words",  32'(words_out),  32'd36);
        chk("stream_words4", 32'(words_out4), 32'd4);

        // ---- enable freeze ----
        in_valid = 1'b1; a = 8'h11;
        step();
        a = 8'h22;
        step();
        in_valid = 1'b0;
        chk("frz_pre_level", 32'(level), 32'd2);
        ena = 1'b0; in_valid = 1'b1; a = 8'h33; out_ready = 1'b1;
        op_load = 1'b1; op_in = 3'b000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("frz_out_valid_%0d", i), 32'(out_valid), 32'h0);
            chk($sformatf("frz_in_ready_%0d", i),  32'(in_ready),  32'h0);
            step();
        end
        chk("frz_level",  32'(level),     32'd2);
        chk("frz_op_cur", 32'(op_cur),    32'h1);
        chk("frz_words",  32'(words_out), 32'd36);
        ena = 1'b1; in_valid = 1'b0; op_load = 1'b0;
        #1;
        chk("frz_y0", 32'(y), 32'h11);
        step();
        chk("frz_y1", 32'(y), 32'h22);
        step();
        out_ready = 1'b0;
        chk("frz_end_level", 32'(level),     32'd0);
        chk("frz_end_words", 32'(words_out), 32'd38);

        // ---- reset mid-stream ----
        in_valid = 1'b1; op_load = 1'b1; op_in = 3'b100; a = 8'h01; b = 8'h02;
        step(); step(); step();
        in_valid = 1'b0; op_load = 1'b0;
        chk("mid_level",  32'(level),  32'd3);
        chk("mid_op_cur", 32'(op_cur), 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_level",  32'(level),     32'd0);
        chk("mid_rst_op_cur", 32'(op_cur),    32'h0);
        chk("mid_rst_words",  32'(words_out), 32'd0);
        chk("mid_rst_valid",  32'(out_valid), 32'h0);
        chk("mid_rst_y",      32'(y),         32'h0);

        // ---- counter wrap: 17 deliveries ----
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            a = 8'(k);
            step();
        end
        in_valid = 1'b0;
        chk("wrap_y_last", 32'(y), 32'(8'(~8'd16)));
        step();
        out_ready = 1'b0;
        chk("wrap_words16", 32'(words_out),  32'd17);
        chk("wrap_words4",  32'(words_out4), 32'd1);
        chk("wrap_level",   32'(level4),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
